// File: rtl/com_seq_control.sv
// Command sequencer: issues timed write strobes on request, with pending
// request buffering, end/timeout handling and sticky status flags.
module com_seq_control #(
  parameter int WRITE_LEN = 1,
  parameter int NUM_CMD   = 16,
  parameter int PEND_MAX  = 3,
  parameter int TIMEOUT   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         NewCom,
  input  logic                         ComEnd,
  output logic                         Write,
  output logic [$clog2(NUM_CMD+1)-1:0] CmdCnt,
  output logic                         Busy,
  output logic                         Done,
  output logic                         TimedOut,
  output logic                         Overflow
);

  localparam int CW = $clog2(NUM_CMD + 1);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int LW = $clog2(WRITE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [CW-1:0] CMD_LAST = CW'(NUM_CMD);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);
  localparam logic [LW-1:0] LEN_INIT = LW'(WRITE_LEN - 1);
  localparam logic [TW-1:0] WAIT_TOP =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_STOP
  } state_t;

  state_t        r_state, w_state;
  logic          r_write, w_write;
  logic [CW-1:0] r_cmdcnt, w_cmdcnt;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_to, w_to;
  logic          r_ovf, w_ovf;
  logic [PW-1:0] r_pend, w_pend;
  logic          r_endreq, w_endreq;
  logic [LW-1:0] r_len, w_len;
  logic [TW-1:0] r_wcnt, w_wcnt;
  logic          w_enter_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_cmdcnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_to     <= 1'b0;
      r_ovf    <= 1'b0;
      r_pend   <= '0;
      r_endreq <= 1'b0;
      r_len    <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state  <= w_state;
      r_write  <= w_write;
      r_cmdcnt <= w_cmdcnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_to     <= w_to;
      r_ovf    <= w_ovf;
      r_pend   <= w_pend;
      r_endreq <= w_endreq;
      r_len    <= w_len;
      r_wcnt   <= w_wcnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_write    = 1'b0;
    w_cmdcnt   = r_cmdcnt;
    w_done     = r_done;
    w_to       = r_to;
    w_ovf      = r_ovf;
    w_pend     = r_pend;
    w_endreq   = r_endreq;
    w_len      = r_len;
    w_wcnt     = r_wcnt;
    w_enter_wr = 1'b0;

    unique case (r_state)
      S_IDLE: w_enter_wr = 1'b1;

      S_WRITE: begin
        if (NewCom) begin
          if (r_pend == PEND_TOP) w_ovf = 1'b1;
          else w_pend = r_pend + 1'b1;
        end
        if (ComEnd) w_endreq = 1'b1;
        if (r_len == '0) begin
          if (r_cmdcnt == CMD_LAST) begin
            w_state = S_STOP;
            w_done  = 1'b1;
          end else if (r_endreq || ComEnd) begin
            w_state = S_STOP;
          end else begin
            w_state = S_WAIT;
            w_wcnt  = '0;
          end
        end else begin
          w_len   = r_len - 1'b1;
          w_write = 1'b1;
        end
      end

      S_WAIT: begin
        if (ComEnd) begin
          w_state = S_STOP;
        end else if (r_pend != '0) begin
          // a same-cycle NewCom replaces the request being consumed
          w_enter_wr = 1'b1;
          if (!NewCom) w_pend = r_pend - 1'b1;
        end else if (NewCom) begin
          w_enter_wr = 1'b1;
        end else if (TIMEOUT > 0 && r_wcnt == WAIT_TOP) begin
          w_state = S_STOP;
          w_to    = 1'b1;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end

      S_STOP: ;

      default: w_state = S_IDLE;
    endcase

    if (w_enter_wr) begin
      w_state  = S_WRITE;
      w_write  = 1'b1;
      w_len    = LEN_INIT;
      w_endreq = 1'b0;
      if (r_cmdcnt != CMD_LAST) w_cmdcnt = r_cmdcnt + 1'b1;
    end

    w_busy = (w_state == S_WRITE) || (w_state == S_WAIT);
  end

  assign Write    = r_write;
  assign CmdCnt   = r_cmdcnt;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign TimedOut = r_to;
  assign Overflow = r_ovf;

endmodule
